uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter UART_RATE, default 1000000, meaning the baud rate in bit/s.
REQ-003 The block SHALL have parameter PARITY_ODD_EVEN, default 1, meaning the parity mode: 0 odd, 1 even.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-006 The block SHALL have port uart_rxd, input, 1 bit: the asynchronous serial line, idle high.
REQ-007 The block SHALL have port data_o, output, 8 bits: the received byte.
REQ-008 The block SHALL have port valid_o, output, 1 bit: a one-cycle pulse marking a completed frame.
REQ-009 The block SHALL have port parity_err_o, output, 1 bit: parity mismatch, qualified by valid_o.
REQ-010 The block SHALL have port frame_err_o, output, 1 bit: stop bit sampled low, qualified by valid_o.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high while in any state other than IDLE.

Function
REQ-012 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-013 The bit period SHALL be BIT_CNT = CLK_FREQ/UART_RATE cycles, using integer division; HALF_CNT = BIT_CNT/2.
REQ-014 uart_rxd SHALL pass through a 2-flop synchronizer reset to 1; all decoding uses the synchronized value.
REQ-015 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 IDLE -> START SHALL occur on a synchronized 1->0 transition; the bit counter clears.
REQ-017 START SHALL sample the line at HALF_CNT: 0 -> DATA, 1 -> IDLE (glitch rejected, no valid_o).
REQ-018 DATA SHALL sample every BIT_CNT cycles after the start mid-point, shifting into bit index 0..7; after index 7 -> PARITY.
REQ-019 PARITY SHALL sample the parity bit; parity_err is set when XOR(data, parity bit) != ~PARITY_ODD_EVEN (even: XOR must be 0; odd: XOR must be 1).
REQ-020 STOP SHALL sample the stop bit; if 1 -> IDLE; if 0 -> BREAK with frame_err=1.
REQ-021 BREAK SHALL wait for the synchronized line to be 1, then go to IDLE; no new start is detected while in BREAK.
REQ-022 valid_o SHALL pulse exactly one cycle, in the cycle after the stop sample; data_o, parity_err_o and frame_err_o update in that same cycle and hold until the next pulse.
REQ-023 Latency SHALL be: valid_o asserts HALF_CNT + 10*BIT_CNT + 3 cycles (±1) after the falling edge at the pin.
REQ-024 A falling edge arriving during the stop-sample cycle SHALL NOT be lost: IDLE is re-entered and edge detection resumes on the next cycle.
REQ-025 Errored bytes SHALL still be delivered; the consumer decides whether to discard them.

Reset
REQ-026 On rst, asynchronously: state=IDLE, counters=0, shift register=0, data_o=0x00, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a valid_o pulse; after release, the first full frame SHALL be received correctly.

Structure
REQ-028 The state encoding and the PARITY_ODD/PARITY_EVEN constants SHALL live in a shared uart_pkg package, also used by uart_tx.
REQ-029 The block SHALL have one natural sub-module, uart_baud_cnt, which implements the bit-period counter with half/full tick outputs; everything else is flat.

Verification
REQ-030 The bench SHALL cover: CLK_FREQ=100M, UART_RATE=1M, even parity, byte 0x51 with parity bit 1 -> valid_o pulse, data_o=0x51, both error flags 0.
REQ-031 The bench SHALL cover: byte 0x51 with parity bit 0, even mode -> data_o=0x51, parity_err_o=1, frame_err_o=0.
REQ-032 The bench SHALL cover: stop bit driven 0, with the line held low 3000 cycles -> frame_err_o=1, busy_o stays high until the line returns high, and no second valid_o pulse.
REQ-033 The bench SHALL cover: a 20-cycle low glitch on an idle line -> no valid_o, and busy_o returns low within 60 cycles.
REQ-034 The bench SHALL cover: back-to-back frames 0x54, 0x57, 0x5A with no idle gap, driven by uart_tx with data incremented by 3 -> three valid_o pulses, correct bytes, no errors.
REQ-035 The bench SHALL cover: rst pulsed at data bit 4 of a frame, then a frame with byte 0xA5 -> no pulse for the aborted frame, then data_o=0xA5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes
// and the parity check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    // Even mode wants XOR(data, parity bit) == 0, odd mode wants it == 1.
    function automatic logic parity_ok(input logic [7:0] data,
                                       input logic       pbit,
                                       input logic       mode);
        return (((^data) ^ pbit) == ~mode);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: free-running modulo BIT_CNT, with a half-period tick
// for the start-bit centre and a full-period tick for every later bit centre.
module uart_baud_cnt #(
    parameter int BIT_CNT  = 100,
    parameter int HALF_CNT = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_half,
    output logic o_full
);

    localparam int CNT_W = $clog2(BIT_CNT) + 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_half = (r_cnt == CNT_W'(HALF_CNT - 1));
    assign o_full = (r_cnt == CNT_W'(BIT_CNT - 1));

    // Counter register: restart on request, wrap after a full bit period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_full) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Errored bytes are still delivered, flagged by parity_err_o / frame_err_o.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ        = 100000000,
    parameter int UART_RATE       = 1000000,
    parameter int PARITY_ODD_EVEN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int   BIT_CNT  = CLK_FREQ / UART_RATE;
    localparam int   HALF_CNT = BIT_CNT / 2;
    localparam logic L_MODE   = (PARITY_ODD_EVEN != 0) ? PARITY_EVEN : PARITY_ODD;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rxd_prev;
    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic        r_pbit;

    uart_state_t w_next;
    logic        w_clr;
    logic        w_half;
    logic        w_full;
    logic        w_shift_en;
    logic        w_pbit_en;
    logic        w_done;

    uart_baud_cnt #(
        .BIT_CNT  (BIT_CNT),
        .HALF_CNT (HALF_CNT)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_half (w_half),
        .o_full (w_full)
    );

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= uart_rxd;
            r_sync2    <= r_sync1;
            r_rxd_prev <= r_sync2;
        end
    end

    // Next-state and control decode.
    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_shift_en = 1'b0;
        w_pbit_en  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rxd_prev && !r_sync2) begin
                    w_next = ST_START;
                    w_clr  = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_half) begin
                    w_clr  = 1'b1;
                    w_next = r_sync2 ? ST_IDLE : ST_DATA;
                end else begin
                    w_next = ST_START;
                end
            end
            ST_DATA: begin
                if (w_full) begin
                    w_shift_en = 1'b1;
                    w_next     = (r_bit_idx == 3'd7) ? ST_PARITY : ST_DATA;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_full) begin
                    w_pbit_en = 1'b1;
                    w_next    = ST_STOP;
                end else begin
                    w_next = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_full) begin
                    w_done = 1'b1;
                    w_next = r_sync2 ? ST_IDLE : ST_BREAK;
                end else begin
                    w_next = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (r_sync2) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_BREAK;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register; busy follows the state being entered so it stays registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            busy_o  <= 1'b0;
        end else begin
            r_state <= w_next;
            busy_o  <= (w_next != ST_IDLE);
        end
    end

    // Receive datapath: LSB-first shift register, bit index and parity bit capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= 8'h00;
            r_bit_idx <= 3'd0;
            r_pbit    <= 1'b0;
        end else begin
            if (w_clr) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
            if (w_pbit_en) begin
                r_pbit <= r_sync2;
            end
        end
    end

    // Result outputs: one-cycle valid pulse, payload and flags held until the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o       <= 8'h00;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            valid_o <= w_done;
            if (w_done) begin
                data_o       <= r_shift;
                parity_err_o <= ~parity_ok(r_shift, r_pbit, L_MODE);
                frame_err_o  <= ~r_sync2;
            end
        end
    end

endmodule
